// File: rtl/switch_control_pkg.sv
// Shared constants, port/state encodings and helpers for the Phoenix switch control.
// Optional statistics counters are enabled with the macro SWITCH_CONTROL_STATS_EN.
package switch_control_pkg;

  localparam int NPORT      = 5;
  localparam int FLIT_WIDTH = 16;
  localparam int PW         = $clog2(NPORT);

  localparam int ADDR_W = 8;
  localparam int X_MSB  = 7;
  localparam int X_LSB  = 4;
  localparam int Y_MSB  = 3;
  localparam int Y_LSB  = 0;

  typedef enum logic [PW-1:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    WAIT  = 3'd2,
    ROUTE = 3'd3,
    GRANT = 3'd4
  } state_e;

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/switch_control_if.sv
// Input-buffer, arbiter and crossbar signals of the switch control.
// master = switch control, slave = buffers/arbiter/crossbar environment.
interface switch_control_if;
  import switch_control_pkg::*;

  logic [NPORT-1:0]            h;
  logic [NPORT*FLIT_WIDTH-1:0] data_in;
  logic [NPORT-1:0]            sender;
  logic [NPORT-1:0]            arb_requests;
  logic                        arb_enable;
  logic [PW-1:0]               arb_selected;
  logic [NPORT-1:0]            ack_h;
  logic [NPORT*PW-1:0]         mux_in;
  logic [NPORT*PW-1:0]         mux_out;
  logic [NPORT-1:0]            free;

  modport master (
    input  h, data_in, sender, arb_selected,
    output arb_requests, arb_enable, ack_h, mux_in, mux_out, free
  );

  modport slave (
    output h, data_in, sender, arb_selected,
    input  arb_requests, arb_enable, ack_h, mux_in, mux_out, free
  );

endinterface

// File: rtl/switch_control_xy_route.sv
// Combinational XY routing: target address + local address -> output port index.
module switch_control_xy_route
  import switch_control_pkg::*;
(
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] local_i,
  output logic [PW-1:0]     port_o
);

  logic [3:0] tx_s;
  logic [3:0] ty_s;
  logic [3:0] lx_s;
  logic [3:0] ly_s;

  assign tx_s = target_i[X_MSB:X_LSB];
  assign ty_s = target_i[Y_MSB:Y_LSB];
  assign lx_s = local_i[X_MSB:X_LSB];
  assign ly_s = local_i[Y_MSB:Y_LSB];

  // X is resolved completely before Y is considered.
  always_comb begin
    port_o = LOCAL;
    if (tx_s > lx_s) begin
      port_o = EAST;
    end else if (tx_s < lx_s) begin
      port_o = WEST;
    end else if (ty_s > ly_s) begin
      port_o = NORTH;
    end else if (ty_s < ly_s) begin
      port_o = SOUTH;
    end else begin
      port_o = LOCAL;
    end
  end

endmodule

// File: rtl/switch_control.sv
// Phoenix router switch control: arbitrates headers, XY-routes them and owns the crossbar tables.
// Define SWITCH_CONTROL_STATS_EN to add grant_count/block_count outputs.
module switch_control
  import switch_control_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    address,
`ifdef SWITCH_CONTROL_STATS_EN
  output logic [15:0]          grant_count,
  output logic [15:0]          block_count,
`endif
  switch_control_if.master     sw
);

  state_e           state_q, state_d;
  logic [PW-1:0]    sel_q, sel_d;
  logic [PW-1:0]    tgt_q, tgt_d;
  logic [NPORT-1:0] free_q, free_d;
  logic [NPORT-1:0] connected_q, connected_d;
  logic [NPORT-1:0] ack_q, ack_d;
  logic [NPORT-1:0] sender_prev_q;
  logic [PW-1:0]    mux_in_q  [NPORT];
  logic [PW-1:0]    mux_in_d  [NPORT];
  logic [PW-1:0]    mux_out_q [NPORT];
  logic [PW-1:0]    mux_out_d [NPORT];
  logic             arb_enable_q;

  logic [NPORT-1:0]  requests_s;
  logic [NPORT-1:0]  release_s;
  logic [ADDR_W-1:0] head_s;
  logic [PW-1:0]     route_s;
  logic              sel_valid_s;
  logic              grant_ok_s;

  assign requests_s  = sw.h & ~connected_q;
  assign release_s   = sender_prev_q & ~sw.sender & connected_q;
  assign head_s      = sw.data_in[sel_q*FLIT_WIDTH +: ADDR_W];
  // An out-of-range or idle selection is treated as "no request behind it".
  assign sel_valid_s = (sel_q < PW'(NPORT)) && requests_s[sel_q];
  assign grant_ok_s  = (state_q == GRANT) && free_q[tgt_q];

  switch_control_xy_route u_xy_route (
    .target_i (head_s),
    .local_i  (address),
    .port_o   (route_s)
  );

  // Next-state logic of the arbitration/grant sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (|requests_s) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        state_d = WAIT;
      end
      WAIT: begin
        sel_d   = sw.arb_selected;
        state_d = ROUTE;
      end
      ROUTE: begin
        if (sel_valid_s) begin
          tgt_d   = route_s;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Connection tables: releases first, then a grant tested against the pre-release free vector.
  always_comb begin
    free_d      = free_q;
    connected_d = connected_q & ~release_s;
    ack_d       = {NPORT{1'b0}};
    mux_in_d    = mux_in_q;
    mux_out_d   = mux_out_q;
    for (int i = 0; i < NPORT; i++) begin
      if (release_s[i]) begin
        free_d[mux_out_q[i]] = 1'b1;
      end else begin
        free_d = free_d;
      end
    end
    if (grant_ok_s) begin
      free_d[tgt_q]      = 1'b0;
      mux_in_d[tgt_q]    = sel_q;
      mux_out_d[sel_q]   = tgt_q;
      connected_d[sel_q] = 1'b1;
      ack_d[sel_q]       = 1'b1;
    end else begin
      ack_d = {NPORT{1'b0}};
    end
  end

  // State, selection and table registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= {PW{1'b0}};
      tgt_q         <= {PW{1'b0}};
      free_q        <= {NPORT{1'b1}};
      connected_q   <= {NPORT{1'b0}};
      ack_q         <= {NPORT{1'b0}};
      sender_prev_q <= {NPORT{1'b0}};
      arb_enable_q  <= 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        mux_in_q[i]  <= {PW{1'b0}};
        mux_out_q[i] <= {PW{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      tgt_q         <= tgt_d;
      free_q        <= free_d;
      connected_q   <= connected_d;
      ack_q         <= ack_d;
      sender_prev_q <= sw.sender;
      arb_enable_q  <= (state_d == ARB);
      mux_in_q      <= mux_in_d;
      mux_out_q     <= mux_out_d;
    end
  end

  assign sw.arb_requests = requests_s;
  assign sw.arb_enable   = arb_enable_q;
  assign sw.ack_h        = ack_q;
  assign sw.free         = free_q;

  for (genvar g = 0; g < NPORT; g++) begin : g_pack
    assign sw.mux_in[g*PW +: PW]  = mux_in_q[g];
    assign sw.mux_out[g*PW +: PW] = mux_out_q[g];
  end

`ifdef SWITCH_CONTROL_STATS_EN
  logic [15:0] grant_count_q;
  logic [15:0] block_count_q;
  logic        grant_blk_s;

  assign grant_blk_s = (state_q == GRANT) && !free_q[tgt_q];

  // Saturating grant/block statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_count_q <= 16'd0;
      block_count_q <= 16'd0;
    end else begin
      if (grant_ok_s) begin
        grant_count_q <= sat_inc(grant_count_q);
      end
      if (grant_blk_s) begin
        block_count_q <= sat_inc(block_count_q);
      end
    end
  end

  assign grant_count = grant_count_q;
  assign block_count = block_count_q;
`endif

endmodule

// File: tb/tb_switch_control.sv
// Self-checking bench for switch_control: cycle model of the grant/release rules plus directed literal checks.
module tb_switch_control;

  logic       clock;
  logic       reset;
  logic [7:0] address;
  logic       cmp_en;
  int         n_cmp;
  int         n_bad;

`ifdef SWITCH_CONTROL_STATS_EN
  logic [15:0] grant_count;
  logic [15:0] block_count;
`endif

  switch_control_if sw ();

  switch_control dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
`ifdef SWITCH_CONTROL_STATS_EN
    .grant_count (grant_count),
    .block_count (block_count),
`endif
    .sw          (sw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- round-robin arbiter stand-in ----------------
  logic [2:0] arb_last;
  assign sw.arb_selected = arb_last;

  always @(posedge clock or posedge reset) begin : arb
    logic       found;
    logic [2:0] pick;
    if (reset) begin
      arb_last <= 3'd4;
    end else if (sw.arb_enable) begin
      found = 1'b0;
      pick  = arb_last;
      for (int k = 1; k <= 5; k++) begin
        if (!found && sw.arb_requests[(int'(arb_last) + k) % 5]) begin
          found = 1'b1;
          pick  = 3'((int'(arb_last) + k) % 5);
        end
      end
      arb_last <= pick;
    end
  end

  // ---------------- behavioural model ----------------
  function automatic logic [2:0] xy_model(input logic [7:0] tgt, input logic [7:0] loc);
    int dx;
    int dy;
    dx = int'(tgt[7:4]) - int'(loc[7:4]);
    dy = int'(tgt[3:0]) - int'(loc[3:0]);
    if (dx > 0) return 3'd0;
    if (dx < 0) return 3'd1;
    if (dy > 0) return 3'd2;
    if (dy < 0) return 3'd3;
    return 3'd4;
  endfunction

  logic [4:0] m_free, m_conn, m_ack, m_sprev;
  logic [2:0] m_src  [5];
  logic [2:0] m_dest [5];
  logic [2:0] m_sel, m_tgt;
  int         m_age;
  int         m_grants, m_blocks;

  // An attempt starts when requests are seen while idle and resolves four edges later.
  always @(posedge clock or posedge reset) begin : mdl
    logic [4:0] req, rel, nfree, nconn, nack;
    if (reset) begin
      m_free   <= 5'h1f;
      m_conn   <= 5'h00;
      m_ack    <= 5'h00;
      m_sprev  <= 5'h00;
      m_sel    <= 3'd0;
      m_tgt    <= 3'd0;
      m_age    <= 0;
      m_grants <= 0;
      m_blocks <= 0;
      for (int i = 0; i < 5; i++) begin
        m_src[i]  <= 3'd0;
        m_dest[i] <= 3'd0;
      end
    end else begin
      req   = sw.h & ~m_conn;
      rel   = m_sprev & ~sw.sender & m_conn;
      nfree = m_free;
      nconn = m_conn & ~rel;
      nack  = 5'h00;
      for (int i = 0; i < 5; i++) if (rel[i]) nfree[m_dest[i]] = 1'b1;
      if (m_age == 0) begin
        if (|req) m_age <= 1;
      end else if (m_age == 2) begin
        m_sel <= sw.arb_selected;
        m_age <= 3;
      end else if (m_age == 3) begin
        if (m_sel < 3'd5 && req[m_sel]) begin
          m_tgt <= xy_model(sw.data_in[int'(m_sel)*16 +: 8], address);
          m_age <= 4;
        end else begin
          m_age <= 0;
        end
      end else if (m_age == 4) begin
        if (m_free[m_tgt]) begin
          nfree[m_tgt]   = 1'b0;
          nconn[m_sel]   = 1'b1;
          nack[m_sel]    = 1'b1;
          m_src[m_tgt]  <= m_sel;
          m_dest[m_sel] <= m_tgt;
          m_grants      <= (m_grants < 65535) ? m_grants + 1 : m_grants;
        end else begin
          m_blocks <= (m_blocks < 65535) ? m_blocks + 1 : m_blocks;
        end
        m_age <= 0;
      end else begin
        m_age <= m_age + 1;
      end
      m_free  <= nfree;
      m_conn  <= nconn;
      m_ack   <= nack;
      m_sprev <= sw.sender;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin : cmp
    logic [14:0] exp_in, exp_out;
    if (cmp_en) begin
      for (int i = 0; i < 5; i++) begin
        exp_in[i*3 +: 3]  = m_src[i];
        exp_out[i*3 +: 3] = m_dest[i];
      end
      check("ack_h", 32'(sw.ack_h), 32'(m_ack));
      check("free", 32'(sw.free), 32'(m_free));
      check("arb_enable", 32'(sw.arb_enable), 32'(m_age == 1));
      check("arb_requests", 32'(sw.arb_requests), 32'(sw.h & ~m_conn));
      check("mux_in", 32'(sw.mux_in), 32'(exp_in));
      check("mux_out", 32'(sw.mux_out), 32'(exp_out));
`ifdef SWITCH_CONTROL_STATS_EN
      check("grant_count", 32'(grant_count), 32'(m_grants));
      check("block_count", 32'(block_count), 32'(m_blocks));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_hdr(input int port, input logic [7:0] hdr);
    sw.data_in[port*16 +: 16] = {8'h00, hdr};
  endtask

  task automatic wait_ack(input string name, input int port, input int budget, output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < budget) begin
      @(posedge clock); #1;
      edges++;
      if (sw.ack_h[port]) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic route_and_release(input logic [7:0] hdr, input logic [2:0] exp_port);
    int edges;
    set_hdr(4, hdr);
    sw.h[4] = 1'b1;
    wait_ack("matrix_ack", 4, 8, edges);
    check("matrix_port", 32'(sw.mux_out[12 +: 3]), 32'(exp_port));
    #1;
    sw.h[4]      = 1'b0;
    sw.sender[4] = 1'b1;
    @(posedge clock); #2;
    sw.sender[4] = 1'b0;
    @(posedge clock); #1;
    check("matrix_release", 32'(sw.free), 32'h1f);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [7:0] hdrs [4];
    logic [2:0] outs [4];
    int         edges;
    n_cmp        = 0;
    n_bad        = 0;
    cmp_en       = 1'b0;
    reset        = 1'b1;
    address      = 8'h11;
    sw.h         = 5'h00;
    sw.sender    = 5'h00;
    sw.data_in   = 80'h0;
    hdrs[0] = 8'h01; outs[0] = 3'd1;
    hdrs[1] = 8'h12; outs[1] = 3'd2;
    hdrs[2] = 8'h10; outs[2] = 3'd3;
    hdrs[3] = 8'h11; outs[3] = 3'd4;

    @(posedge clock); #2;
    cmp_en = 1'b1;
    @(posedge clock); #1;
    check("rst_free", 32'(sw.free), 32'h1f);
    check("rst_ack", 32'(sw.ack_h), 32'h0);
    check("rst_enable", 32'(sw.arb_enable), 32'h0);
    #1;
    reset = 1'b0;

    // Single route: LOCAL -> EAST, ack after the 5th edge.
    @(posedge clock); #2;
    set_hdr(4, 8'h31);
    sw.h = 5'b10000;
    repeat (4) begin
      @(posedge clock); #1;
      check("single_early_ack", 32'(sw.ack_h), 32'h0);
    end
    @(posedge clock); #1;
    check("single_ack", 32'(sw.ack_h), 32'h10);
    check("single_mux_out4", 32'(sw.mux_out[12 +: 3]), 32'd0);
    check("single_mux_in0", 32'(sw.mux_in[0 +: 3]), 32'd4);
    check("single_free", 32'(sw.free), 32'h1e);
    #1;
    sw.h         = 5'h00;
    sw.sender[4] = 1'b1;
    @(posedge clock); #2;
    sw.sender[4] = 1'b0;
    @(posedge clock); #1;
    check("release_free", 32'(sw.free), 32'h1f);
    #1;

    // Routing matrix from LOCAL.
    for (int i = 0; i < 4; i++) route_and_release(hdrs[i], outs[i]);

    // Contention: EAST and WEST both to NORTH.
    set_hdr(0, 8'h12);
    set_hdr(1, 8'h12);
    sw.h = 5'b00011;
    wait_ack("contend_first_ack", 0, 10, edges);
    check("contend_mux_in2", 32'(sw.mux_in[6 +: 3]), 32'd0);
    #1;
    sw.h[0]      = 1'b0;
    sw.sender[0] = 1'b1;
    repeat (12) begin
      @(posedge clock); #1;
      check("contend_hold", 32'(sw.ack_h[1]), 32'd0);
    end
    #1;
    sw.sender[0] = 1'b0;
    wait_ack("contend_second_ack", 1, 20, edges);
    check("contend_not_early", 32'(edges >= 2), 32'd1);
    check("contend_mux_in2b", 32'(sw.mux_in[6 +: 3]), 32'd1);
    check("contend_free", 32'(sw.free), 32'h1b);
    #1;
    sw.h[1]      = 1'b0;
    sw.sender[1] = 1'b1;

    // Spurious select: SOUTH withdraws its request before ROUTE.
    @(posedge clock); #2;
    set_hdr(3, 8'h31);
    sw.h[3] = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    sw.h[3] = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      check("spurious_no_ack", 32'(sw.ack_h), 32'h0);
    end
    check("spurious_free", 32'(sw.free), 32'h1b);
    check("spurious_mux_out1", 32'(sw.mux_out[3 +: 3]), 32'd2);
`ifdef SWITCH_CONTROL_STATS_EN
    check("spurious_grants", 32'(grant_count), 32'd7);
`endif
    #1;

    // Reset asserted while an attempt for EAST sits in ROUTE.
    @(posedge clock); #2;
    set_hdr(0, 8'h31);
    sw.h = 5'b00001;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_free", 32'(sw.free), 32'h1f);
    check("midrst_ack", 32'(sw.ack_h), 32'h0);
    check("midrst_enable", 32'(sw.arb_enable), 32'h0);
    sw.sender = 5'h00;
    @(posedge clock); #2;
    reset = 1'b0;
    wait_ack("after_reset_ack", 0, 5, edges);
    check("after_reset_mux_out0", 32'(sw.mux_out[0 +: 3]), 32'd0);
    #1;
    sw.h = 5'h00;
    repeat (4) @(posedge clock);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_control.md
Name: switch_control

Overview:
- Phoenix router switch control: the stage directly upstream of RoundRobinArbiter, and the only consumer of its result.
- Collects header requests from the NPORT input buffers and drives the arbiter's requests/enable.
- Consumes selectedOutput, XY-routes the chosen header, and grants the output if it is free.
- Holds the crossbar connection tables (mux_in/mux_out) and the free vector; releases a connection when its input's sender drops.

Parameters:
- NPORT, `NPORT (5), number of router ports; encoding EAST=0 WEST=1 NORTH=2 SOUTH=3 LOCAL=4
- FLIT_WIDTH, 16, flit width; header target address in bits [7:0]
- PW, $clog2(NPORT), port-index width (localparam)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- address  in  8  this router's XY address: [7:4]=X, [3:0]=Y
- h  in  NPORT  per-input header-ready request, held until ack_h
- data_in  in  NPORT*FLIT_WIDTH  head flit of each input buffer, port i at slice i
- sender  in  NPORT  per-input "packet in transit"; its falling edge releases the connection
- arb_requests  out  NPORT  to arbiter requests
- arb_enable  out  1  to arbiter enable, one-cycle pulse
- arb_selected  in  PW  from arbiter selectedOutput
- ack_h  out  NPORT  one-cycle header-accepted pulse per input
- mux_in  out  NPORT*PW  per output: index of the driving input
- mux_out  out  NPORT*PW  per input: index of the destination output
- free  out  NPORT  per output: 1 = unallocated

Behaviour:
- Reset values:
  - state=IDLE; arb_enable=0; ack_h=0; free=all 1; mux_in=0; mux_out=0; sel_reg=0; tgt_reg=0.
  - Asynchronous assert mid-operation aborts any grant in progress; no ack is issued.
- Request masking: arb_requests = h & ~connected, where connected[i]=1 while input i owns an output.
- State IDLE: if |arb_requests -> ARB, else stay.
- State ARB: arb_enable=1 for exactly this cycle -> WAIT.
- State WAIT: arb_enable=0; latch sel_reg<=arb_selected -> ROUTE.
  - The arbiter updates on the enable rising edge, so arb_selected is stable here.
- State ROUTE: if arb_requests[sel_reg]==0 -> IDLE with no grant.
  - This covers the arbiter returning its last port when no request exists.
  - Otherwise compute tgt_reg by XY routing on data_in[sel_reg][7:0] -> GRANT.
- XY routing, with target tx=[7:4], ty=[3:0] and local lx,ly from address; unsigned 4-bit compares:
  - tx>lx -> EAST; tx<lx -> WEST
  - else ty>ly -> NORTH; ty<ly -> SOUTH
  - else LOCAL
- State GRANT, if free[tgt_reg]=1, at the exiting edge:
  - free[tgt]<=0, mux_in[tgt]<=sel, mux_out[sel]<=tgt, connected[sel]<=1, ack_h[sel]<=1.
  - Then -> IDLE.
- State GRANT, if free[tgt_reg]=0: no table change, no ack -> IDLE. The arbiter rotates on retry.
- ack_h: registered, high for exactly one cycle, one-hot.
- Latency: h sampled at edge E -> ack_h high after edge E+4 (IDLE, ARB, WAIT, ROUTE, GRANT).
- Release: a registered sender_d detects sender[i] 1->0 for a connected i. On that edge:
  - free[mux_out[i]]<=1, connected[i]<=0.
  - mux tables retain stale values.
- Simultaneous events:
  - Release and GRANT in the same cycle: GRANT tests the pre-release free value, so a just-freed output is grantable from the next attempt.
  - Release and grant never target the same input, because connected inputs are masked.
- U-turn to the arrival port is legal at this level; XY never produces it for well-formed traffic.

Optional Feature:
- Macro: SWITCH_CONTROL_STATS_EN.
- Defined:
  - Adds outputs grant_count[15:0] and block_count[15:0].
  - grant_count increments on each successful GRANT; block_count increments on each GRANT rejected by free=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines.vh: NPORT, port encodings EAST/WEST/NORTH/SOUTH/LOCAL, state encodings IDLE/ARB/WAIT/ROUTE/GRANT, address field positions.
- One natural sub-module, xy_route: combinational target address + local address -> port index. It is reusable in the routing tests.
- The arbiter stays a separate instance outside this block.

Test Plan:
- Reset: assert reset mid-ROUTE with h=5'b00001 -> immediately free=5'b11111, ack_h=0, arb_enable=0; after release, normal grant within 5 edges.
- Single route: address=8'h11, LOCAL h=1, header 8'h31 -> ack_h=5'b10000 on the 5th edge, mux_out[4]=EAST(0), mux_in[0]=4, free=5'b11110.
- Routing matrix: address 8'h11, headers 8'h01/8'h12/8'h10/8'h11 -> WEST/NORTH/SOUTH/LOCAL.
- Contention: EAST and WEST both request NORTH (header 8'h12) -> first granted, second rejected and retried; granted only after the first's sender falls, one cycle later at earliest.
- Release: drop sender on a connected input -> free bit for its output returns to 1 on the next edge; the input's h is re-arbitrable.
- Spurious select: h withdrawn before ROUTE -> no ack, tables unchanged; with STATS_EN, block_count unchanged and grant_count unchanged.
